// File: rtl/sram_if.sv
// sram_if: read/write port bundle for the sram data array.
// The cache controller drives the master side; the memory is the slave.
interface sram_if #(
   parameter int WORDSIZE = 64,
   parameter int WIDTH    = 512,
   parameter int LOGDEPTH = 9
);
   logic [LOGDEPTH-1:0]         readAddr;
   logic [WIDTH-1:0]            readData;
   logic [LOGDEPTH-1:0]         writeAddr;
   logic [WIDTH-1:0]            writeData;
   logic [WIDTH/WORDSIZE-1:0]   writeEnable;

   modport master (output readAddr, writeAddr, writeData, writeEnable, input readData);
   modport slave  (input readAddr, writeAddr, writeData, writeEnable, output readData);
endinterface

// File: rtl/sram.sv
// sram: 1R1W synchronous line memory with per-word write enables and a
// registered read-first output; the async active-low reset clears only readData.
module sram #(
   parameter int WORDSIZE = 64,
   parameter int WIDTH    = 512,
   parameter int LOGDEPTH = 9
) (
   input  logic   clk,
   input  logic   reset,
   sram_if.slave  bus
);
   localparam int WORDS = WIDTH / WORDSIZE;

   if (WIDTH % WORDSIZE != 0) begin : g_bad_width
      $error("sram: WIDTH (%0d) must be a multiple of WORDSIZE (%0d)", WIDTH, WORDSIZE);
   end

   logic [WIDTH-1:0] mem [2**LOGDEPTH];
   logic [WIDTH-1:0] read_data_d, read_data_q;

   always_comb read_data_d = mem[bus.readAddr];

   always_ff @(posedge clk or negedge reset)
      if (!reset) read_data_q <= '0;
      else        read_data_q <= read_data_d;

   // Contents survive reset, so the array has no reset term; writes are only gated.
   always_ff @(posedge clk)
      if (reset)
         for (int k = 0; k < WORDS; k++)
            if (bus.writeEnable[k])
               mem[bus.writeAddr][k*WORDSIZE +: WORDSIZE] <= bus.writeData[k*WORDSIZE +: WORDSIZE];

   assign bus.readData = read_data_q;
endmodule

// File: tb/tb_sram.sv
// tb_sram: directed and randomized checks of sram against a line-array model.
module tb_sram;
   localparam int WS = 64, W = 512, LD = 9, WORDS = W / WS, DEPTH = 1 << LD;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sram_if #(.WORDSIZE(WS), .WIDTH(W), .LOGDEPTH(LD)) bus ();
   sram #(.WORDSIZE(WS), .WIDTH(W), .LOGDEPTH(LD)) dut (.clk(clk), .reset(reset), .bus(bus));

   logic [W-1:0] model [DEPTH];
   bit           written [DEPTH];
   int           n_tests = 0, n_fail = 0;
   logic [W-1:0] pat_a5, line_val;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_line();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // One clock of traffic: expected read is the pre-write line (read-first), 0 under reset.
   task automatic cycle(input string tag, input logic [LD-1:0] ra, input logic [LD-1:0] wa,
                        input logic [W-1:0] wd, input logic [WORDS-1:0] we);
      logic [W-1:0] exp_rd;
      bit ok;
      bus.readAddr = ra; bus.writeAddr = wa; bus.writeData = wd; bus.writeEnable = we;
      @(posedge clk);
      exp_rd = reset ? model[ra] : '0;
      ok = !reset || written[ra];
      if (reset) begin
         for (int k = 0; k < WORDS; k++)
            if (we[k]) model[wa][k*WS +: WS] = wd[k*WS +: WS];
         if (we == '1) written[wa] = 1'b1;
      end
      #1;
      if (ok) check(tag, bus.readData, exp_rd);
   endtask

   initial begin
      pat_a5 = {64{8'hA5}};
      bus.readAddr = '0; bus.writeAddr = '0; bus.writeData = '0; bus.writeEnable = '0;
      #1 reset = 1'b0;
      #1 check("reset_init", bus.readData, '0);
      cycle("in_reset", 9'd4, 9'd4, '1, '1);
      cycle("in_reset", 9'd4, 9'd4, '1, '1);
      @(negedge clk) reset = 1'b1;

      for (int i = 0; i < DEPTH; i++) cycle("stream_wr", 9'd0, LD'(i), W'(i), '1);
      for (int i = 0; i < DEPTH; i++) begin
         cycle("stream_rd", LD'(i), 9'd0, '0, '0);
         check("stream_val", bus.readData, W'(i));
      end

      cycle("a5_wr", 9'd0, 9'h1FF, pat_a5, '1);
      cycle("a5_rd", 9'h1FF, 9'd0, '0, '0);
      check("a5_line", bus.readData, pat_a5);
      cycle("line0_rd", 9'h000, 9'd0, '0, '0);
      check("line0_not_a5", bus.readData, '0);

      cycle("part_ones", 9'd0, 9'd5, '1, '1);
      cycle("part_zero", 9'd0, 9'd5, '0, 8'b0000_0100);
      cycle("part_rd", 9'd5, 9'd0, '0, '0);
      line_val = '1;
      line_val[191:128] = '0;
      check("partial", bus.readData, line_val);

      cycle("rdw_init", 9'd0, 9'd7, W'(1), '1);
      cycle("rdw_same", 9'd7, 9'd7, W'(2), '1);
      check("rdw_old", bus.readData, W'(1));
      cycle("rdw_next", 9'd7, 9'd0, '0, '0);
      check("rdw_new", bus.readData, W'(2));

      cycle("zero_en", 9'd0, 9'd3, rnd_line(), '0);
      cycle("zero_en_rd", 9'd3, 9'd0, '0, '0);
      check("zero_en_line", bus.readData, W'(3));

      #2 reset = 1'b0;
      #1 check("async_rst", bus.readData, '0);
      cycle("rst_write", 9'd9, 9'd9, '1, '1);
      check("rst_hold", bus.readData, '0);
      @(negedge clk) reset = 1'b1;
      cycle("post_rst9", 9'd9, 9'd0, '0, '0);
      check("post_rst_line9", bus.readData, W'(9));
      cycle("post_rst1ff", 9'h1FF, 9'd0, '0, '0);
      check("post_rst_a5", bus.readData, pat_a5);

      for (int i = 0; i < 400; i++)
         cycle("random", LD'($urandom_range(0, 15)), LD'($urandom_range(0, 15)),
               rnd_line(), WORDS'($urandom));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
